// File: rtl/tl_grant_pkg.sv
// Shared types and constants for the grant beat collector.
// Holds line geometry, the block-get grant type and the FSM state enum.
package tl_grant_pkg;

    localparam logic [3:0] G_TYPE_GET_DATA_BLOCK = 4'd4;
    localparam int         BEATS_PER_LINE        = 8;
    localparam int         BEAT_W                = 64;
    localparam int         LINE_W                = 512;
    localparam int         CNT_W                 = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    function automatic logic is_multibeat(
        input logic       builtin,
        input logic [3:0] g_type
    );
        return !builtin || (g_type == G_TYPE_GET_DATA_BLOCK);
    endfunction

endpackage

// File: rtl/grant_beat_collector.sv
// Gathers grant beats into a full 512-bit line and holds it for release.
// Build option: GRANT_BEAT_CHECK_EN enables the sticky beat-order check.
module grant_beat_collector
    import tl_grant_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [2:0]        io_in_bits_addr_beat,
    input  logic              io_in_bits_client_xact_id,
    input  logic [1:0]        io_in_bits_manager_xact_id,
    input  logic              io_in_bits_is_builtin_type,
    input  logic [3:0]        io_in_bits_g_type,
    input  logic [BEAT_W-1:0] io_in_bits_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic              io_out_bits_client_xact_id,
    output logic [1:0]        io_out_bits_manager_xact_id,
    output logic              io_out_bits_is_builtin_type,
    output logic [3:0]        io_out_bits_g_type,
    output logic [LINE_W-1:0] io_out_bits_data,
    output logic [CNT_W-1:0]  io_cnt,
    output logic              io_beat_err
);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]                      r_cnt;
    logic [BEATS_PER_LINE-1:0][BEAT_W-1:0] r_lanes;
    logic                                  r_cid;
    logic [1:0]                            r_mid;
    logic                                  r_builtin;
    logic [3:0]                            r_gtype;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_multi;
    logic [CNT_W-1:0] w_first_lane;

    // Handshake flags come from state alone, so no ready-to-ready path.
    assign io_in_ready  = (r_state == IDLE) || (r_state == COLLECT);
    assign io_out_valid = (r_state == FULL);
    assign w_in_fire    = io_in_valid && io_in_ready;
    assign w_out_fire   = io_out_valid && io_out_ready;

    assign w_multi = is_multibeat(io_in_bits_is_builtin_type,
                                  io_in_bits_g_type);
    assign w_first_lane = w_multi ? '0 : io_in_bits_addr_beat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = w_multi ? COLLECT : FULL;
                end
            end
            COLLECT: begin
                if (w_in_fire && (r_cnt == CNT_W'(BEATS_PER_LINE - 1))) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_lanes   <= '0;
            r_cid     <= 1'b0;
            r_mid     <= '0;
            r_builtin <= 1'b0;
            r_gtype   <= '0;
        end else if (w_in_fire) begin
            if (r_state == IDLE) begin
                r_cid                 <= io_in_bits_client_xact_id;
                r_mid                 <= io_in_bits_manager_xact_id;
                r_builtin             <= io_in_bits_is_builtin_type;
                r_gtype               <= io_in_bits_g_type;
                r_lanes               <= '0;
                r_lanes[w_first_lane] <= io_in_bits_data;
                r_cnt                 <= w_multi ? CNT_W'(1) : '0;
            end else begin
                // Counter wraps 7 -> 0 on the last beat of the line.
                r_lanes[r_cnt] <= io_in_bits_data;
                r_cnt          <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign io_out_bits_client_xact_id  = r_cid;
    assign io_out_bits_manager_xact_id = r_mid;
    assign io_out_bits_is_builtin_type = r_builtin;
    assign io_out_bits_g_type          = r_gtype;
    assign io_out_bits_data            = r_lanes;
    assign io_cnt                      = r_cnt;

`ifdef GRANT_BEAT_CHECK_EN
    logic [CNT_W-1:0] w_exp_beat;
    logic             w_mismatch;
    logic             r_beat_err;

    assign w_exp_beat = (r_state == COLLECT) ? r_cnt : '0;
    assign w_mismatch = w_in_fire
                     && ((r_state == COLLECT) || w_multi)
                     && (io_in_bits_addr_beat != w_exp_beat);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_beat_err <= 1'b0;
        end else if (w_mismatch) begin
            r_beat_err <= 1'b1;
        end
    end

    assign io_beat_err = r_beat_err;
`else
    assign io_beat_err = 1'b0;
`endif

endmodule
